// File: rtl/q_measure.sv
// q_measure: settle-then-average front end for the bisection current controller.
// After every i_ref change (or a start pulse) it waits SETTLE_CYCLES, averages
// 2^LOG2_SAMPLES valid ADC samples and presents the truncated mean with a
// one-cycle ready pulse.
// Optional feature: define Q_MEASURE_TIMEOUT_EN to enable the adc_valid gap
// watchdog (TIMEOUT_CYCLES); without it ACQUIRE waits indefinitely and
// timeout is constant 0.
//
// state   | meaning
// IDLE    | waiting for a trigger, busy low
// SETTLE  | counting SETTLE_CYCLES while the analog loop settles
// ACQUIRE | accumulating valid ADC samples
// DONE    | one cycle, new q_measured valid, ready high

module q_measure #(
  parameter int BUS_WIDTH      = 10,
  parameter int SETTLE_CYCLES  = 64,
  parameter int LOG2_SAMPLES   = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] i_ref,
  input  logic                 adc_valid,
  input  logic [BUS_WIDTH-1:0] adc_data,
  output logic [BUS_WIDTH-1:0] q_measured,
  output logic                 ready,
  output logic                 busy,
  output logic                 timeout
);

  localparam int ACC_W = BUS_WIDTH + LOG2_SAMPLES;
  localparam int SCW   = $clog2(SETTLE_CYCLES + 1);
  localparam int NCW   = LOG2_SAMPLES + 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [NCW-1:0] SAMP_LAST   = NCW'((1 << LOG2_SAMPLES) - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, ACQUIRE, DONE} state_t;

  state_t               state_q, state_d;
  logic [BUS_WIDTH-1:0] i_ref_last_q, i_ref_last_d;
  logic [SCW-1:0]       settle_q, settle_d;
  logic [NCW-1:0]       samp_q, samp_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [BUS_WIDTH-1:0] q_q, q_d;
  logic                 ready_q, ready_d;
  logic                 timeout_q, timeout_d;

  logic                 trigger;
  logic                 settle_done;
  logic                 last_sample;
  logic                 gap_expire;
  logic [ACC_W-1:0]     acc_sum;
  logic [ACC_W-1:0]     acc_shift;

  assign trigger     = enable & (start | (i_ref != i_ref_last_q));
  assign settle_done = (state_q == SETTLE) && (settle_q == SETTLE_LAST);
  assign last_sample = (state_q == ACQUIRE) && adc_valid && (samp_q == SAMP_LAST);
  assign acc_sum     = acc_q + ACC_W'(adc_data);
  assign acc_shift   = acc_sum >> LOG2_SAMPLES;

`ifdef Q_MEASURE_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);

  logic [GW-1:0] gap_q, gap_d;

  // Gap counter register, only meaningful while acquiring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) gap_q <= '0;
    else     gap_q <= gap_d;
  end

  // Count consecutive invalid cycles in ACQUIRE; any valid sample restarts it.
  always_comb begin
    gap_d = '0;
    if (state_q == ACQUIRE && !adc_valid) gap_d = gap_q + 1'b1;
  end

  assign gap_expire = (state_q == ACQUIRE) && !adc_valid && (gap_q == GAP_LAST);
`else
  assign gap_expire = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      i_ref_last_q <= '0;
      settle_q     <= '0;
      samp_q       <= '0;
      acc_q        <= '0;
      q_q          <= '0;
      ready_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_ref_last_q <= i_ref_last_d;
      settle_q     <= settle_d;
      samp_q       <= samp_d;
      acc_q        <= acc_d;
      q_q          <= q_d;
      ready_q      <= ready_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next state: disable beats trigger, trigger beats normal progress.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else if (trigger) begin
      state_d = SETTLE;
    end else begin
      case (state_q)
        SETTLE:  if (settle_done) state_d = ACQUIRE;
        ACQUIRE: begin
          if (last_sample)     state_d = DONE;
          else if (gap_expire) state_d = IDLE;
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Counters, accumulator and registered ready/timeout. The mean is latched on
  // the edge that accumulates the final sample so it is valid with ready in DONE.
  always_comb begin
    i_ref_last_d = enable ? i_ref : i_ref_last_q;
    settle_d     = settle_q;
    samp_d       = samp_q;
    acc_d        = acc_q;
    q_d          = q_q;
    ready_d      = 1'b0;
    timeout_d    = 1'b0;
    if (enable && !trigger) begin
      case (state_q)
        SETTLE: begin
          settle_d = settle_q + 1'b1;
          if (settle_done) begin
            acc_d  = '0;
            samp_d = '0;
          end
        end
        ACQUIRE: begin
          if (adc_valid) begin
            acc_d  = acc_sum;
            samp_d = samp_q + 1'b1;
            if (last_sample) begin
              q_d     = acc_shift[BUS_WIDTH-1:0];
              ready_d = 1'b1;
            end
          end
          timeout_d = gap_expire;
        end
        default: ;
      endcase
    end else begin
      settle_d = '0;
    end
  end

  // Outputs.
  always_comb begin
    busy       = (state_q == SETTLE) || (state_q == ACQUIRE);
    ready      = ready_q;
    timeout    = timeout_q;
    q_measured = q_q;
  end

endmodule

// File: doc/q_measure.md
Name: q_measure

Overview:
- Upstream stage of the bisection current controller. Produces the `q_measured` sample and the `ready` strobe that the controller consumes.
- After each change of the controller's `i_ref`, waits a fixed settling interval for the analog loop to settle.
- Then accumulates 2^LOG2_SAMPLES ADC readings of the quality-factor estimate.
- Outputs their truncated mean with a one-cycle `ready` pulse.

Parameters:
- BUS_WIDTH, 10, width of ADC data, `i_ref` and `q_measured`.
- SETTLE_CYCLES, 64, clock cycles waited after a trigger before sampling starts (min 1).
- LOG2_SAMPLES, 3, log2 of samples averaged per measurement (0..6).
- TIMEOUT_CYCLES, 1024, watchdog limit for `adc_valid` gaps; used only with Q_MEASURE_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  block active; low forces IDLE.
- start  input  1  one-cycle request to measure without an `i_ref` change.
- i_ref  input  BUS_WIDTH  current reference from the bisection controller; a change triggers a measurement.
- adc_valid  input  1  `adc_data` valid this cycle.
- adc_data  input  BUS_WIDTH  unsigned Q sample.
- q_measured  output  BUS_WIDTH  last completed mean; held between measurements.
- ready  output  1  one-cycle pulse when a new `q_measured` is valid.
- busy  output  1  high in SETTLE or ACQUIRE.
- timeout  output  1  one-cycle pulse on watchdog expiry; constant 0 without the macro.

Behaviour:
- Reset values:
  - All outputs are 0: `q_measured`, `ready`, `busy`, `timeout`.
  - Internal state: `i_ref_last` = 0, accumulator = 0, counters = 0, state = IDLE.
- `i_ref_last` registers `i_ref` every cycle while `enable` is high.
- trigger = `enable` & (`start` | (`i_ref` != `i_ref_last`)).
- States: IDLE, SETTLE, ACQUIRE, DONE.
- IDLE:
  - `busy` = 0.
  - On trigger: go to SETTLE, settle counter = 0.
- SETTLE:
  - Counter increments each cycle.
  - When the counter reaches SETTLE_CYCLES-1: clear the accumulator and sample counter, go to ACQUIRE.
  - Trigger SETTLE_CYCLES=1 → exactly one SETTLE cycle.
- ACQUIRE:
  - Each cycle with `adc_valid`=1: accumulator += `adc_data`, sample counter += 1.
  - Cycles without `adc_valid` are ignored.
  - After the 2^LOG2_SAMPLES-th valid sample is accumulated, go to DONE.
- DONE (one cycle):
  - `q_measured` <= accumulator >> LOG2_SAMPLES, truncated toward zero.
  - `ready` = 1 for this cycle only, registered.
  - Next state is IDLE.
  - `ready` therefore rises 1 cycle after the last sample edge.
  - Minimum trigger-to-`ready` latency is SETTLE_CYCLES + 2^LOG2_SAMPLES + 1 cycles with `adc_valid` held high.
- Accumulator width is BUS_WIDTH+LOG2_SAMPLES bits and never overflows. No rounding.
- Retrigger: a trigger in SETTLE or ACQUIRE restarts SETTLE from count 0 and discards the partial accumulator. No `ready` is issued for the aborted measurement.
- Trigger in DONE: DONE completes normally (`ready` pulses), then the FSM goes to SETTLE instead of IDLE.
- `enable` low in any state: next state is IDLE, partial data is discarded, no `ready`, `q_measured` is held.
- `enable` rising with `i_ref` != `i_ref_last` (stale from before disable) counts as a trigger.
- `rst` mid-operation: immediate return to reset values. Any `ready` in flight is lost.
- `adc_valid` during IDLE, SETTLE or DONE is ignored.

Optional Feature:
- Macro `Q_MEASURE_TIMEOUT_EN`.
- Defined:
  - In ACQUIRE, a gap counter counts consecutive cycles with `adc_valid`=0 and resets on each valid sample.
  - When it reaches TIMEOUT_CYCLES: pulse `timeout` for 1 cycle and go to IDLE.
  - No `ready` is issued and `q_measured` is held.
  - A trigger in the same cycle takes priority: restart SETTLE, no `timeout` pulse.
- Undefined:
  - No gap counter; ACQUIRE waits indefinitely.
  - `timeout` tied to 0.

Test Plan:
1. Defaults; `enable`=1; `i_ref` 0→512; `adc_valid`=1 with `adc_data` = 100,101,…,107 → `ready` pulses exactly once, 64+8+1 cycles after the change; `q_measured`=103; `busy` falls with `ready`.
2. `adc_data` = 1023 ×8 → `q_measured`=1023, no overflow. Then samples 0,0,0,0,0,0,0,7 → `q_measured`=0 (truncation).
3. `i_ref` changes 512→256 during the 4th ACQUIRE sample → SETTLE restarts; the next `ready` appears 64+8+1 cycles after the second change; only one `ready` pulse in total.
4. `enable` dropped mid-SETTLE, then restored with `i_ref` unchanged → IDLE, no `ready`, `q_measured` held. A `start` pulse then produces a normal measurement.
5. `adc_valid` toggling 1,0,0,1,… → only valid cycles counted; `ready` after the 8th valid sample; mean correct.
6. With `Q_MEASURE_TIMEOUT_EN`, TIMEOUT_CYCLES=16: stop `adc_valid` after 3 samples → `timeout` pulses on the 16th idle cycle, state returns to IDLE, no `ready`. Without the macro → `timeout` stays 0 and `busy` stays 1.
